// File: rtl/cache_main_memory.sv
// Block-granular main memory behind the write-through cache.
// Serves 128-bit block reads and writes with a fixed access latency and a
// one-cycle ready pulse.
module cache_main_memory #(
    parameter int unsigned LATENCY = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         req,
    input  logic         we,
    input  logic [9:0]   addr,
    input  logic [127:0] wdata,
    output logic [127:0] rdata,
    output logic         ready,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

    // Word w of the flat word space holds w at power-up.
    function automatic logic [63:0][127:0] init_mem();
        logic [63:0][127:0] m;
        for (int b = 0; b < 64; b++) begin
            for (int k = 0; k < 4; k++) begin
                m[b][32*k +: 32] = 32'(b * 4 + k);
            end
        end
        return m;
    endfunction

    // Power-up image only; reset deliberately leaves the array alone.
    logic [63:0][127:0] mem = init_mem();

    state_e       state_q;
    logic [3:0]   cnt_q;
    logic         we_q;
    logic [5:0]   blk_q;
    logic [127:0] wdata_q;
    logic         commit;

    // Block offset bits are don't-care.
    logic unused_addr;
    assign unused_addr = ^addr[3:0];

    // The access lands on the edge where the BUSY countdown reaches zero.
    assign commit = (state_q == StBusy) && (cnt_q == 4'd0);

    // Array write port; reset forces IDLE, so an aborted write never commits.
    always_ff @(posedge clock) begin
        if (commit && we_q) begin
            mem[blk_q] <= wdata_q;
        end
    end

    // Request FSM with registered ready/busy/rdata.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            blk_q   <= 6'd0;
            wdata_q <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ready <= 1'b0;
            unique case (state_q)
                // Leaving DONE re-enters IDLE; a still-held req is taken on
                // that same edge so back-to-back requests run every LATENCY+1.
                StIdle, StDone: begin
                    if (req) begin
                        we_q    <= we;
                        blk_q   <= addr[9:4];
                        wdata_q <= wdata;
                        cnt_q   <= CntLoad;
                        state_q <= StBusy;
                        busy    <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                StBusy: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StDone;
                        ready   <= 1'b1;
                        if (!we_q) begin
                            rdata <= mem[blk_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
